// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI slave front end.
//   SPI_WORD_W          default bits per SPI word
//   SPI_SYNC_STAGES     default synchronizer depth on SPI inputs
//   SPI_MIN_CLK_PER_SCK minimum clk cycles per SCK period that is supported
//   spi_state_t         frame state (idle while CS high, active while CS low)
package spi_pkg;

   localparam int unsigned SPI_WORD_W          = 8;
   localparam int unsigned SPI_SYNC_STAGES     = 2;
   localparam int unsigned SPI_MIN_CLK_PER_SCK = 8;

   typedef enum logic {
      SPI_IDLE,
      SPI_ACTIVE
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous input, with
// single-cycle rise/fall strobes taken from the last stage against one extra
// registered copy.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   din       asynchronous input
//   rise      one-cycle strobe on a synchronized 0->1 transition
//   fall      one-cycle strobe on a synchronized 1->0 transition
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_out;
      end
   end

   assign rise = sync_out & ~prev_q;
   assign fall = ~sync_out & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI mode-0 slave running in the system clock domain.
// SCK/CS_n/MOSI are oversampled; received words are assembled MSB first and
// handed over with a data_ready/read_ack handshake, while tx_data is shifted
// out MSB first on MISO.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   spi_sck       SPI clock (CPOL=0)
//   spi_cs_n      chip select, active low
//   spi_mosi      master-out data
//   spi_miso      slave-out data (MISO_IDLE while deselected)
//   tx_data       word returned to the master, loaded at each word start
//   rx_data       last accepted received word
//   data_ready    rx_data valid, held until read_ack
//   read_ack      single-cycle acknowledge from the consumer
//   overrun       sticky: a word completed while data_ready was still high
//   frame_active  synchronized CS asserted
module spi_slave_rx_tx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = SPI_WORD_W,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES,
   parameter logic        MISO_IDLE   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sck,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  data_ready,
   input  logic                  read_ack,
   output logic                  overrun,
   output logic                  frame_active
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_sync;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_sck),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_q <= '0;
      else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_sync = mosi_q[SYNC_STAGES-1];

   // Frame FSM
   spi_state_t state_q, state_d;
   logic       word_start, frame_end, sample_en, shift_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SPI_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      word_start = 1'b0;
      frame_end  = 1'b0;
      sample_en  = 1'b0;
      shift_en   = 1'b0;
      case (state_q)
         SPI_IDLE: begin
            if (cs_fall) begin
               state_d    = SPI_ACTIVE;
               word_start = 1'b1;
               // an SCK rise coinciding with CS fall samples the first bit
               sample_en  = sck_rise;
            end
         end
         SPI_ACTIVE: begin
            if (cs_rise) begin
               state_d   = SPI_IDLE;
               frame_end = 1'b1;
            end else begin
               sample_en = sck_rise;
               shift_en  = sck_fall;
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   assign frame_active = (state_q == SPI_ACTIVE);

   // Datapath. tx_shift holds only the bits still to be sent; the MSB goes
   // straight to spi_miso at load time.
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_cur;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-2:0] tx_shift;
   logic                  word_done_q;

   assign bit_cnt_cur = word_start ? '0 : bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         spi_miso    <= MISO_IDLE;
         word_done_q <= 1'b0;
      end else begin
         word_done_q <= 1'b0;
         if (word_start) begin
            tx_shift <= tx_data[DATA_WIDTH-2:0];
            spi_miso <= tx_data[DATA_WIDTH-1];
            bit_cnt  <= '0;
         end else if (frame_end) begin
            bit_cnt  <= '0;
            spi_miso <= MISO_IDLE;
         end else if (shift_en) begin
            if (bit_cnt == '0) begin
               tx_shift <= tx_data[DATA_WIDTH-2:0];
               spi_miso <= tx_data[DATA_WIDTH-1];
            end else begin
               tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
               spi_miso <= tx_shift[DATA_WIDTH-2];
            end
         end
         if (sample_en) begin
            rx_shift    <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
            bit_cnt     <= (bit_cnt_cur == LAST_BIT) ? '0 : bit_cnt_cur + 1'b1;
            word_done_q <= (bit_cnt_cur == LAST_BIT);
         end
      end
   end

   // Handshake: a completed word is presented one cycle after its last
   // sample; read_ack in that cycle frees the slot for the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         data_ready <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (read_ack && !frame_active) overrun <= 1'b0;
         if (word_done_q) begin
            if (!data_ready || read_ack) begin
               rx_data    <= rx_shift;
               data_ready <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (read_ack) begin
            data_ready <= 1'b0;
         end
      end
   end

endmodule
